// File: rtl/fp_exp_pkg.sv
// fp_exp_pkg: shared widths, ID-width helper and in-flight tag type for fp_exp_sched.
package fp_exp_pkg;
  localparam int SIG_WIDTH_DEF = 23;
  localparam int EXP_WIDTH_DEF = 8;
  localparam int ID_MAX_W = 4;
  function automatic int fp_w(input int sig_w, input int exp_w);
    return sig_w + exp_w + 1;
  endfunction
  function automatic int id_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from the slot after the last accepted one.
module rr_arbiter import fp_exp_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  // Walk farthest to nearest so the nearest pending requester is the one left standing.
  always_comb begin
    grant = '0;
    gnt_id = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !rst && req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= ID_W'(NUM_REQ - 1);
    else if (|(req & grant)) ptr <= gnt_id;
endmodule

// File: rtl/fp_exp_sched.sv
// fp_exp_sched: shares one pipelined fp exp unit among NUM_REQ share-split requesters,
// returning each result tagged with its requester ID.
module fp_exp_sched import fp_exp_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int SIG_WIDTH = SIG_WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int LATENCY = 3,
  localparam int ID_W = id_w(NUM_REQ),
  localparam int FP_W = fp_w(SIG_WIDTH, EXP_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_g,
  input  logic [NUM_REQ*FP_W-1:0] req_e,
  output logic [FP_W-1:0]         exp_a,
  input  logic [FP_W-1:0]         exp_z,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    busy
);
  logic [ID_W-1:0] gnt_id;
  logic            accept;
  logic            pipe_busy;
  tag_t            iss_tag;
  tag_t            out_tag;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (issue_en),
    .req   (req_valid),
    .grant (req_ready),
    .gnt_id(gnt_id)
  );
  assign accept = |(req_valid & req_ready);
  // exp_a only moves on accept so the unit input never toggles on idle cycles.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exp_a <= '0;
      iss_tag <= '0;
    end else begin
      iss_tag <= '{valid: accept, id: ID_MAX_W'(gnt_id)};
      if (accept) exp_a <= req_g[int'(gnt_id)*FP_W +: FP_W] ^ req_e[int'(gnt_id)*FP_W +: FP_W];
    end
  if (LATENCY == 0) begin : g_nopipe
    assign out_tag = iss_tag;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    tag_t pipe [LATENCY];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= iss_tag;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) pipe_busy = pipe_busy | pipe[i].valid;
    end
    assign out_tag = pipe[LATENCY-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= out_tag.valid;
      if (out_tag.valid) begin
        rsp_id <= ID_W'(out_tag.id);
        rsp_data <= exp_z;
      end
    end
  assign busy = iss_tag.valid | pipe_busy | rsp_valid;
endmodule

// File: tb/tb_fp_exp_sched.sv
// tb_fp_exp_sched: scoreboard bench driving a LATENCY=3 and a LATENCY=0 instance with shared stimulus.
module tb_fp_exp_sched;
  localparam int N = 4;
  localparam int W = 32;
  typedef struct {int id; logic [W-1:0] data; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_en = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [W-1:0] g [N];
  logic [W-1:0] e [N];
  logic [N*W-1:0] req_g, req_e;
  logic [N-1:0] rdy3, rdy0;
  logic [W-1:0] a3, a0, z3, z0, d3, d0;
  logic v3, v0, b3, b0;
  logic [1:0] id3, id0;
  logic [W-1:0] upipe [3];
  exp_t q3[$], q0[$];
  exp_t x3, x0;
  int glog[$];
  int errors = 0, checks = 0, mptr = N - 1, mlast = -1, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_g[i*W +: W] = g[i];
      req_e[i*W +: W] = e[i];
    end
  fp_exp_sched #(.NUM_REQ(N), .SIG_WIDTH(23), .EXP_WIDTH(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid), .req_ready(rdy3),
    .req_g(req_g), .req_e(req_e), .exp_a(a3), .exp_z(z3), .rsp_valid(v3), .rsp_id(id3),
    .rsp_data(d3), .busy(b3));
  fp_exp_sched #(.NUM_REQ(N), .SIG_WIDTH(23), .EXP_WIDTH(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid), .req_ready(rdy0),
    .req_g(req_g), .req_e(req_e), .exp_a(a0), .exp_z(z0), .rsp_valid(v0), .rsp_id(id0),
    .rsp_data(d0), .busy(b0));
  // Stand-in exp unit: exact for the directed points, an arbitrary bijection elsewhere.
  function automatic logic [W-1:0] fexp(input logic [W-1:0] x);
    if (x == 32'h3F800000) return 32'h402DF854;
    if (x == 32'h0) return 32'h3F800000;
    return {x[15:0], x[31:16]} ^ 32'h5A5AA5A5;
  endfunction
  always @(posedge clk) begin
    upipe[0] <= fexp(a3);
    upipe[1] <= upipe[0];
    upipe[2] <= upipe[1];
  end
  assign z3 = upipe[2];
  assign z0 = fexp(a0);
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  // Reference: grant is the first valid requester after the last accepted one.
  task automatic step();
    int gi;
    int ai;
    logic [W-1:0] dv;
    @(negedge clk);
    gi = -1;
    ai = -1;
    if (issue_en && !rst)
      for (int k = 1; k <= N; k++)
        if (gi < 0 && req_valid[2'((mptr + k) % N)]) gi = (mptr + k) % N;
    for (int i = 0; i < N; i++) if (rdy3[i]) ai = i;
    chk("grant_l3", 32'(rdy3), gi < 0 ? 32'd0 : 32'd1 << gi);
    chk("grant_l0", 32'(rdy0), gi < 0 ? 32'd0 : 32'd1 << gi);
    glog.push_back(ai);
    mlast = gi;
    if (gi >= 0) begin
      dv = fexp(g[gi] ^ e[gi]);
      q3.push_back('{gi, dv, cyc + 5});
      q0.push_back('{gi, dv, cyc + 2});
      mptr = gi;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_exp_a", a3 | a0, 32'd0);
    chk("rst_rsp", {29'd0, v3, v0, b3 | b0}, 32'd0);
    chk("rst_rsp_id", 32'({id3, id0}), 32'd0);
    chk("rst_rsp_data", d3 | d0, 32'd0);
    chk("rst_ready", 32'({rdy3, rdy0}), 32'd0);
    q3.delete();
    q0.delete();
    mptr = N - 1;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (v3) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_l3_unexpected: got id=%0d data=%h expected none", id3, d3);
        end else begin
          x3 = q3.pop_front();
          chk("rsp_l3_id", 32'(id3), 32'(x3.id));
          chk("rsp_l3_data", d3, x3.data);
          chk("rsp_l3_cycle", cyc, x3.cyc);
        end
      end else if (q3.size() > 0 && q3[0].cyc < cyc) begin
        x3 = q3.pop_front();
        checks++; errors++;
        $display("FAIL rsp_l3_missing: got nothing expected id=%0d at cycle %0d", x3.id, x3.cyc);
      end
      if (v0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_l0_unexpected: got id=%0d data=%h expected none", id0, d0);
        end else begin
          x0 = q0.pop_front();
          chk("rsp_l0_id", 32'(id0), 32'(x0.id));
          chk("rsp_l0_data", d0, x0.data);
          chk("rsp_l0_cycle", cyc, x0.cyc);
        end
      end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
        x0 = q0.pop_front();
        checks++; errors++;
        $display("FAIL rsp_l0_missing: got nothing expected id=%0d at cycle %0d", x0.id, x0.cyc);
      end
    end
  initial begin
    for (int i = 0; i < N; i++) begin
      g[i] = '0;
      e[i] = '0;
    end
    issue_en = 1'b1;
    req_valid = '1;
    #1;
    chk("reset_ready", 32'({rdy3, rdy0}), 32'd0);
    chk("reset_outs", a3 | d3 | a0 | d0 | {29'd0, v3 | v0, b3, b0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    g[0] = 32'h3F800000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    chk("single_exp_a", a3, 32'h3F800000);
    chk("single_busy_l3_t1", 32'(b3), 32'd1);
    chk("single_busy_l0_t1", 32'(b0), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      step();
      chk("single_busy_l3", 32'(b3), 32'(k <= 5));
      chk("single_busy_l0", 32'(b0), 32'(k <= 2));
    end
    chk("exp_a_hold", a3, 32'h3F800000);
    g[2] = 32'h12345678;
    e[2] = 32'h12345678;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("recombine_exp_a", a3, 32'h0);
    repeat (6) step();
    do_reset();
    glog.delete();
    req_valid = 4'b1111;
    repeat (8) step();
    req_valid = '0;
    for (int i = 0; i < 8; i++) chk("rr_order", glog[i], i % N);
    repeat (6) step();
    glog.delete();
    req_valid = 4'b1010;
    repeat (2) step();
    req_valid = '0;
    step();
    req_valid = 4'b1010;
    repeat (2) step();
    req_valid = '0;
    chk("sparse_0", glog[0], 1);
    chk("sparse_1", glog[1], 3);
    chk("sparse_idle", glog[2], -1);
    chk("sparse_3", glog[3], 1);
    chk("sparse_4", glog[4], 3);
    repeat (6) step();
    for (int c = 0; c < 300; c++) begin
      issue_en = !(c >= 50 && c < 53) && ($urandom_range(0, 9) != 0);
      step();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || mlast == i) begin
          g[i] = $urandom;
          e[i] = $urandom;
          req_valid[i] = 1'($urandom_range(0, 1));
        end
    end
    issue_en = 1'b1;
    req_valid = '0;
    repeat (8) step();
    chk("drain_busy", 32'({b3, b0}), 32'd0);
    chk("drain_queues", q3.size() + q0.size(), 32'd0);
    req_valid = 4'b1111;
    repeat (3) step();
    do_reset();
    req_valid = '0;
    repeat (6) step();
    glog.delete();
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    chk("post_reset_grant", glog[0], 0);
    repeat (8) step();
    chk("final_busy", 32'({b3, b0}), 32'd0);
    chk("final_queues", q3.size() + q0.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
